alu_cmd_sequencer: RTL and testbench

Upstream issue stage for basic_alu. It accepts ALU commands (op, A, B) over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time to the combinational basic_alu and registers Result/Zero/Carry. It presents each response downstream over a second valid/ready handshake, with backpressure.

---
 rtl/alu_cmd_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Issue stage in front of the combinational basic_alu. Commands arrive
//   over a valid/ready handshake and are buffered in a DEPTH-entry FIFO.
//   One command at a time is loaded into the registered alu_* outputs. The
//   ALU's Result/Zero/Carry are captured one cycle later and presented
//   downstream over a second valid/ready handshake.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op/cmd_a/cmd_b          command opcode and operands
//   alu_A/alu_B/alu_Sel         registered operands/select to basic_alu
//   alu_Result/Zero/Carry       combinational results from basic_alu
//   rsp_valid/rsp_ready         response handshake
//   rsp_result/zero/carry       captured ALU outputs
//   rsp_op/rsp_err              original opcode, illegal-opcode flag
//   done_count                  completed responses, wraps modulo 256
//   busy                        FSM not idle or FIFO holding commands
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] alu_A,
  output logic [7:0] alu_B,
  output logic [2:0] alu_Sel,
  input  logic [7:0] alu_Result,
  input  logic       alu_Zero,
  input  logic       alu_Carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic [2:0] rsp_op,
  output logic       rsp_err,
  output logic [7:0] done_count,
  output logic       busy
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  state_t        state_next;

  logic [18:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [2:0]    head_op;
  logic [7:0]    head_a;
  logic [7:0]    head_b;
  logic          head_illegal;

  logic          err;
  logic [2:0]    cur_op;

  // Full/empty come only from the registered count, so a pop in the same
  // cycle never frees room for a push, and a fresh push is not popped
  // until the following cycle.
  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  assign {head_op, head_a, head_b} = fifo_mem[rd_ptr];
  assign head_illegal = (head_op > 3'd4);

  assign busy = (state != IDLE) || !empty;

  // Command storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and pop decision. A response handshake with more work
  // queued goes straight back to EXEC so back-to-back commands take two
  // cycles each.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          pop        = !empty;
          state_next = empty ? IDLE : EXEC;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load the ALU on pop, capture the ALU one cycle later, and
  // retire the response on the downstream handshake. Illegal opcodes drive
  // a harmless ADD select and report a zeroed result with rsp_err set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_A      <= '0;
      alu_B      <= '0;
      alu_Sel    <= '0;
      err        <= 1'b0;
      cur_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
      done_count <= '0;
    end else begin
      if (pop) begin
        alu_A   <= head_a;
        alu_B   <= head_b;
        alu_Sel <= head_illegal ? 3'b000 : head_op;
        err     <= head_illegal;
        cur_op  <= head_op;
      end
      if (state == EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_result <= err ? 8'h00 : alu_Result;
        rsp_zero   <= err ? 1'b0 : alu_Zero;
        rsp_carry  <= err ? 1'b0 : alu_Carry;
        rsp_op     <= cur_op;
        rsp_err    <= err;
      end
      if ((state == RESP) && rsp_ready) begin
        rsp_valid  <= 1'b0;
        done_count <= done_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Self-checking bench for alu_cmd_sequencer. The bench plays the part of
//   basic_alu, keeps a queue of outstanding commands as its reference model
//   and compares every meaningful cycle, plus a set of literal expectations
//   for the directed scenarios.
module tb_alu_cmd_sequencer;

  localparam int DEPTH    = 4;
  localparam int AW       = 2;
  localparam int CLK_HALF = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [7:0] alu_A;
  logic [7:0] alu_B;
  logic [2:0] alu_Sel;
  logic [7:0] alu_Result;
  logic       alu_Zero;
  logic       alu_Carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_carry;
  logic [2:0] rsp_op;
  logic       rsp_err;
  logic [7:0] done_count;
  logic       busy;

  always #CLK_HALF clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_Sel    (alu_Sel),
    .alu_Result (alu_Result),
    .alu_Zero   (alu_Zero),
    .alu_Carry  (alu_Carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .done_count (done_count),
    .busy       (busy)
  );

  // Arithmetic meaning of each opcode: {carry, result}. SUB carry is the
  // borrow out of an unsigned subtraction. Unused selects give a loud value.
  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    alu_fn = {1'b0, a} + {1'b0, b};
      3'd1:    alu_fn = {1'b0, a} - {1'b0, b};
      3'd2:    alu_fn = {1'b0, a & b};
      3'd3:    alu_fn = {1'b0, a | b};
      3'd4:    alu_fn = {1'b0, ~b};
      default: alu_fn = 9'h1A5;
    endcase
  endfunction

  // Stand-in for basic_alu.
  assign {alu_Carry, alu_Result} = alu_fn(alu_Sel, alu_A, alu_B);
  assign alu_Zero = (alu_Result == 8'h00);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t        model_q[$];
  logic [7:0]  model_done;
  int          n_compared;
  int          n_mismatched;

  logic        hold_valid;
  logic [13:0] held_fields;
  cmd_t        m_exp;
  logic        m_legal;
  logic [8:0]  m_res;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name, input int cycles);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: nothing within %0d cycles, required an event", name, cycles);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one command; leaves cmd_valid asserted if it was never taken.
  task automatic apply_stimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input int max_cycles, output bit accepted);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    accepted  = 1'b0;
    for (int i = 0; i < max_cycles && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) accepted = 1'b1;
      step();
    end
    if (accepted) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int max_cycles, output logic [7:0] res,
                          output logic z, output logic c, output logic [2:0] op, output logic e);
    bit got;
    got = 1'b0;
    res = '0; z = 1'b0; c = 1'b0; op = '0; e = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        got = 1'b1;
        res = rsp_result; z = rsp_zero; c = rsp_carry; op = rsp_op; e = rsp_err;
      end
      step();
    end
    if (!got) report_timeout(name, max_cycles);
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
      step();
    end
    if (!got) report_timeout(name, max_cycles);
  endtask

  // Reference model and per-cycle comparison. model_q holds every accepted
  // command not yet retired downstream; its head is the one being answered.
  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
      model_done = '0;
      hold_valid = 1'b0;
    end else begin
      check_output("done_count", 32'(done_count), 32'(model_done));
      check_output("busy", 32'(busy), 32'(model_q.size() != 0));
      if (model_q.size() < DEPTH) check_output("cmd_ready_room", 32'(cmd_ready), 32'd1);
      if (model_q.size() == DEPTH + 1) check_output("cmd_ready_full", 32'(cmd_ready), 32'd0);
      if (model_q.size() == 0) check_output("rsp_valid_empty", 32'(rsp_valid), 32'd0);
      if (hold_valid) begin
        check_output("hold_valid", 32'(rsp_valid), 32'd1);
        check_output("hold_fields", 32'({rsp_result, rsp_zero, rsp_carry, rsp_op, rsp_err}), 32'(held_fields));
      end
      if (rsp_valid && model_q.size() > 0) begin
        m_exp   = model_q[0];
        m_legal = (m_exp.op <= 3'd4);
        m_res   = m_legal ? alu_fn(m_exp.op, m_exp.a, m_exp.b) : 9'h000;
        check_output("rsp_result", 32'(rsp_result), 32'(m_res[7:0]));
        check_output("rsp_zero", 32'(rsp_zero), 32'(m_legal && (m_res[7:0] == 8'h00)));
        check_output("rsp_carry", 32'(rsp_carry), 32'(m_res[8]));
        check_output("rsp_op", 32'(rsp_op), 32'(m_exp.op));
        check_output("rsp_err", 32'(rsp_err), 32'(!m_legal));
        check_output("alu_A", 32'(alu_A), 32'(m_exp.a));
        check_output("alu_B", 32'(alu_B), 32'(m_exp.b));
        check_output("alu_Sel", 32'(alu_Sel), 32'(m_legal ? m_exp.op : 3'b000));
      end
      if (rsp_valid && rsp_ready && model_q.size() > 0) begin
        void'(model_q.pop_front());
        model_done = model_done + 8'd1;
      end
      hold_valid  = rsp_valid && !rsp_ready;
      held_fields = {rsp_result, rsp_zero, rsp_carry, rsp_op, rsp_err};
      if (cmd_valid && cmd_ready) model_q.push_back(cmd_t'({cmd_op, cmd_a, cmd_b}));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  bit         acc;
  int         n_acc;
  int         n_rsp;
  int         zeros;
  logic [7:0] r;
  logic       z, c, e;
  logic [2:0] o;
  logic [7:0] bp_res [6];
  int         threshold;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) step();

    // Reset state.
    $display("[TB] reset state");
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_done_count", 32'(done_count), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_alu_A", 32'(alu_A), 32'd0);
    check_output("rst_alu_Sel", 32'(alu_Sel), 32'd0);
    rst = 1'b0;
    step();
    check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single ADD and its latency.
    $display("[TB] single ADD");
    rsp_ready = 1'b1;
    apply_stimulus(3'd0, 8'h0A, 8'h14, 4, acc);
    check_output("add_accepted", 32'(acc), 32'd1);
    check_output("add_valid_n", 32'(rsp_valid), 32'd0);
    step();
    check_output("add_valid_n1", 32'(rsp_valid), 32'd0);
    step();
    check_output("add_valid_n2", 32'(rsp_valid), 32'd1);
    check_output("add_result", 32'(rsp_result), 32'h1E);
    check_output("add_zero", 32'(rsp_zero), 32'd0);
    check_output("add_carry", 32'(rsp_carry), 32'd0);
    step();
    check_output("add_done_count", 32'(done_count), 32'd1);

    // Overflow, zero and NOT.
    $display("[TB] overflow and zero");
    rsp_ready = 1'b0;
    apply_stimulus(3'd0, 8'hFF, 8'h01, 4, acc);
    apply_stimulus(3'd1, 8'h64, 8'h64, 4, acc);
    apply_stimulus(3'd4, 8'h00, 8'h55, 4, acc);
    rsp_ready = 1'b1;
    wait_rsp("ovf_rsp0", 10, r, z, c, o, e);
    check_output("ovf_result", 32'(r), 32'h00);
    check_output("ovf_zero", 32'(z), 32'd1);
    check_output("ovf_carry", 32'(c), 32'd1);
    wait_rsp("sub_rsp1", 10, r, z, c, o, e);
    check_output("sub_result", 32'(r), 32'h00);
    check_output("sub_zero", 32'(z), 32'd1);
    wait_rsp("not_rsp2", 10, r, z, c, o, e);
    check_output("not_result", 32'(r), 32'hAA);
    check_output("not_zero", 32'(z), 32'd0);

    // Backpressure: DEPTH buffered plus one in flight.
    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(3'd0, 8'(i + 1), 8'h10, 8, acc);
      if (acc) n_acc++;
    end
    check_output("bp_accepted", 32'(n_acc), 32'd5);
    check_output("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check_output("bp_held_valid", 32'(rsp_valid), 32'd1);
    check_output("bp_held_result", 32'(rsp_result), 32'h11);
    rsp_ready = 1'b1;
    fork
      begin
        apply_stimulus(3'd0, 8'd6, 8'h10, 3, acc);
        check_output("bp_sixth_accepted", 32'(acc), 32'd1);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          wait_rsp("bp_drain", 10, r, z, c, o, e);
          bp_res[k] = r;
        end
      end
    join
    for (int k = 0; k < 6; k++) check_output("bp_order", 32'(bp_res[k]), 32'(8'h11 + 8'(k)));

    // Illegal opcode followed by a legal OR.
    $display("[TB] illegal op");
    rsp_ready = 1'b0;
    apply_stimulus(3'd5, 8'h33, 8'h44, 4, acc);
    wait_valid("ill_valid", 6);
    check_output("ill_err", 32'(rsp_err), 32'd1);
    check_output("ill_result", 32'(rsp_result), 32'h00);
    check_output("ill_op", 32'(rsp_op), 32'd5);
    check_output("ill_alu_Sel", 32'(alu_Sel), 32'd0);
    check_output("ill_zero", 32'(rsp_zero), 32'd0);
    check_output("ill_carry", 32'(rsp_carry), 32'd0);
    apply_stimulus(3'd3, 8'hF0, 8'h0F, 4, acc);
    rsp_ready = 1'b1;
    wait_rsp("ill_rsp", 10, r, z, c, o, e);
    wait_rsp("or_rsp", 10, r, z, c, o, e);
    check_output("or_result", 32'(r), 32'hFF);
    check_output("or_err", 32'(e), 32'd0);
    check_output("or_op", 32'(o), 32'd3);

    // Randomized traffic against the model, light then heavy backpressure.
    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      threshold = (i < 400) ? 30 : 75;
      cmd_valid = ($urandom_range(0, 99) < 60);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      rsp_ready = ($urandom_range(0, 99) < threshold);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && model_q.size() != 0; i++) step();
    if (model_q.size() != 0) report_timeout("random_drain", 40);

    // Asynchronous reset while a response is waiting.
    $display("[TB] reset mid-operation");
    rsp_ready = 1'b0;
    apply_stimulus(3'd0, 8'h01, 8'h02, 4, acc);
    apply_stimulus(3'd3, 8'h10, 8'h20, 4, acc);
    apply_stimulus(3'd2, 8'hFF, 8'h0F, 4, acc);
    wait_valid("mid_valid", 6);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("mid_rsp_result", 32'(rsp_result), 32'd0);
    check_output("mid_rsp_op", 32'(rsp_op), 32'd0);
    check_output("mid_done_count", 32'(done_count), 32'd0);
    check_output("mid_busy", 32'(busy), 32'd0);
    check_output("mid_alu_A", 32'(alu_A), 32'd0);
    check_output("mid_alu_B", 32'(alu_B), 32'd0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
      step();
    end
    check_output("mid_no_rsp", 32'(n_rsp), 32'd0);
    check_output("mid_done_after", 32'(done_count), 32'd0);
    check_output("mid_cmd_ready", 32'(cmd_ready), 32'd1);

    // 256 back-to-back ANDs wrap done_count back to zero.
    $display("[TB] counter wrap");
    n_acc = 0;
    zeros = 0;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          apply_stimulus(3'd2, 8'hF0, 8'h0F, 10, acc);
          if (acc) n_acc++;
        end
      end
      begin
        for (int k = 0; k < 256; k++) begin
          wait_rsp("wrap_rsp", 12, r, z, c, o, e);
          if (z) zeros++;
        end
      end
    join
    check_output("wrap_accepted", 32'(n_acc), 32'd256);
    check_output("wrap_zeros", 32'(zeros), 32'd256);
    check_output("wrap_done_count", 32'(done_count), 32'd0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
